// File: rtl/mips_mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_mc_ctrl_pkg
//  Shared encodings for the multi-cycle MIPS control slice: FSM state codes,
//  opcode/func constants, ALU operation codes, datapath mux select codes,
//  error codes and the instruction class used between decode and the FSM.
// -----------------------------------------------------------------------------
package mips_mc_ctrl_pkg;

    // FSM state encodings (3 bits)
    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    // Opcodes (Inst_code[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (Inst_code[5:0])
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_JR   = 6'b001000;

    // ALU operation codes
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_SLLV = 3'b111;

    // PC source select
    localparam logic [1:0] PC_S_INC  = 2'b00;
    localparam logic [1:0] PC_S_RS   = 2'b01;
    localparam logic [1:0] PC_S_BR   = 2'b10;
    localparam logic [1:0] PC_S_JUMP = 2'b11;

    // Destination register select
    localparam logic [1:0] WRS_RD  = 2'b00;
    localparam logic [1:0] WRS_RT  = 2'b01;
    localparam logic [1:0] WRS_R31 = 2'b10;

    // Register write data select
    localparam logic [1:0] WDS_ALU = 2'b00;
    localparam logic [1:0] WDS_MEM = 2'b01;
    localparam logic [1:0] WDS_PC  = 2'b10;

    // Sticky error codes
    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_MEM_TO = 2'b10;

    // Instruction class as seen by the FSM
    typedef enum logic [3:0] {
        CLS_R_ALU,
        CLS_I_ALU,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_BNE,
        CLS_J,
        CLS_JAL,
        CLS_JR,
        CLS_ILL
    } inst_class_e;

endpackage

// File: rtl/mips_ctrl_decode.sv
// -----------------------------------------------------------------------------
// mips_ctrl_decode
//  Purely combinational instruction decoder for the multi-cycle controller.
//  Ports:
//    op         in   6   opcode field
//    func       in   6   R-type function field
//    inst_class out      instruction class for the FSM
//    alu_op     out  3   ALU operation for EX (and held through MEM/WB)
//    imm_s      out  1   1 sign-extend immediate, 0 zero-extend
//    rt_imm_s   out  1   ALU B source: 0 register, 1 immediate
//    illegal    out  1   opcode/func combination not supported
// -----------------------------------------------------------------------------
module mips_ctrl_decode
    import mips_mc_ctrl_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    output inst_class_e inst_class,
    output logic [2:0]  alu_op,
    output logic        imm_s,
    output logic        rt_imm_s,
    output logic        illegal
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        inst_class = CLS_ILL;
        alu_op     = ALU_AND;
        imm_s      = 1'b0;
        rt_imm_s   = 1'b0;

        case (op)
            OP_RTYPE: begin
                inst_class = CLS_R_ALU;
                case (func)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLLV: alu_op = ALU_SLLV;
                    FN_JR:   inst_class = CLS_JR;
                    default: inst_class = CLS_ILL;
                endcase
            end
            OP_ADDI: begin
                inst_class = CLS_I_ALU;
                alu_op     = ALU_ADD;
                imm_s      = 1'b1;
                rt_imm_s   = 1'b1;
            end
            OP_ANDI: begin
                inst_class = CLS_I_ALU;
                alu_op     = ALU_AND;
                rt_imm_s   = 1'b1;
            end
            OP_ORI: begin
                inst_class = CLS_I_ALU;
                alu_op     = ALU_OR;
                rt_imm_s   = 1'b1;
            end
            OP_XORI: begin
                inst_class = CLS_I_ALU;
                alu_op     = ALU_XOR;
                rt_imm_s   = 1'b1;
            end
            OP_LW: begin
                inst_class = CLS_LW;
                alu_op     = ALU_ADD;
                imm_s      = 1'b1;
                rt_imm_s   = 1'b1;
            end
            OP_SW: begin
                inst_class = CLS_SW;
                alu_op     = ALU_ADD;
                imm_s      = 1'b1;
                rt_imm_s   = 1'b1;
            end
            // Branches compare rs against rt, so the ALU B input stays on the register.
            OP_BEQ: begin
                inst_class = CLS_BEQ;
                alu_op     = ALU_SUB;
                imm_s      = 1'b1;
            end
            OP_BNE: begin
                inst_class = CLS_BNE;
                alu_op     = ALU_SUB;
                imm_s      = 1'b1;
            end
            OP_J:    inst_class = CLS_J;
            OP_JAL:  inst_class = CLS_JAL;
            default: inst_class = CLS_ILL;
        endcase

        illegal = (inst_class == CLS_ILL);
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// -----------------------------------------------------------------------------
// mips_mc_ctrl
//  Multi-cycle control FSM for a MIPS R/I/J datapath. Sequences
//  IF/ID/EX/MEM/WB around one shared memory handshake, drives the datapath
//  selects/enables, counts retired instructions and halts on an illegal
//  instruction or a memory timeout.
//  Ports:
//    clk, rst            clock (rising edge), async active-low reset
//    OP, func, ZF        instruction fields from IR, ALU zero flag
//    mem_ready           memory completes the current request this cycle
//    mem_req/mem_is_inst memory request, 1 = instruction fetch
//    IR_Write, PC_Write  IR / PC load enables; PC_s selects the new PC
//    Write_Reg, w_r_s, wr_data_s  register file write controls
//    rt_imm_s, imm_s, ALU_OP      ALU operand / operation controls
//    Mem_Write           data store strobe (qualified by mem_req)
//    halted, err_code    sticky halt flag and reason
//    inst_cnt            retired instruction count (wraps)
// -----------------------------------------------------------------------------
module mips_mc_ctrl
    import mips_mc_ctrl_pkg::*;
#(
    parameter int MEM_TO = 16,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       OP,
    input  logic [5:0]       func,
    input  logic             ZF,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_is_inst,
    output logic             IR_Write,
    output logic             PC_Write,
    output logic [1:0]       PC_s,
    output logic             Write_Reg,
    output logic [1:0]       w_r_s,
    output logic [1:0]       wr_data_s,
    output logic             rt_imm_s,
    output logic             imm_s,
    output logic [2:0]       ALU_OP,
    output logic             Mem_Write,
    output logic             halted,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] inst_cnt
);

    // Wait counter only needs to reach MEM_TO-1; the timeout fires on that cycle.
    localparam int              WAIT_W    = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TO - 1);

    logic [2:0]        state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;

    inst_class_e dec_cls;
    logic [2:0]  dec_alu_op;
    logic        dec_imm_s;
    logic        dec_rt_imm_s;
    logic        dec_illegal;

    logic        wants_mem;
    logic        mem_done;
    logic        timeout;
    logic        retire;
    logic        err_set;
    logic [1:0]  err_val;

    mips_ctrl_decode u_decode (
        .op         (OP),
        .func       (func),
        .inst_class (dec_cls),
        .alu_op     (dec_alu_op),
        .imm_s      (dec_imm_s),
        .rt_imm_s   (dec_rt_imm_s),
        .illegal    (dec_illegal)
    );

    // Handshake bookkeeping is derived from the state alone so it is
    // independent of the reset gating applied to the outputs.
    assign wants_mem = (state == S_IF) || (state == S_MEM);
    assign mem_done  = wants_mem && mem_ready;
    assign timeout   = wants_mem && !mem_ready && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt   = state;
        retire      = 1'b0;
        err_set     = 1'b0;
        err_val     = ERR_NONE;

        mem_req     = 1'b0;
        mem_is_inst = 1'b0;
        IR_Write    = 1'b0;
        PC_Write    = 1'b0;
        PC_s        = PC_S_INC;
        Write_Reg   = 1'b0;
        w_r_s       = WRS_RD;
        wr_data_s   = WDS_ALU;
        rt_imm_s    = 1'b0;
        imm_s       = 1'b0;
        ALU_OP      = ALU_AND;
        Mem_Write   = 1'b0;
        halted      = 1'b0;

        // ALU controls stay stable from EX through WB so the address/result
        // the datapath computed remains valid while memory or the regfile uses it.
        if ((state == S_EX) || (state == S_MEM) || (state == S_WB)) begin
            ALU_OP   = dec_alu_op;
            rt_imm_s = dec_rt_imm_s;
            imm_s    = dec_imm_s;
        end

        case (state)
            S_IF: begin
                mem_req     = 1'b1;
                mem_is_inst = 1'b1;
                if (mem_done) begin
                    IR_Write  = 1'b1;
                    PC_Write  = 1'b1;
                    PC_s      = PC_S_INC;
                    state_nxt = S_ID;
                end else if (timeout) begin
                    err_set   = 1'b1;
                    err_val   = ERR_MEM_TO;
                    state_nxt = S_HALT;
                end
            end

            S_ID: begin
                if (dec_illegal) begin
                    err_set   = 1'b1;
                    err_val   = ERR_ILLEGAL;
                    state_nxt = S_HALT;
                end else begin
                    case (dec_cls)
                        CLS_J: begin
                            PC_Write  = 1'b1;
                            PC_s      = PC_S_JUMP;
                            retire    = 1'b1;
                            state_nxt = S_IF;
                        end
                        // PC already holds old PC+4 here, which is the link value.
                        CLS_JAL: begin
                            PC_Write  = 1'b1;
                            PC_s      = PC_S_JUMP;
                            Write_Reg = 1'b1;
                            w_r_s     = WRS_R31;
                            wr_data_s = WDS_PC;
                            retire    = 1'b1;
                            state_nxt = S_IF;
                        end
                        CLS_JR: begin
                            PC_Write  = 1'b1;
                            PC_s      = PC_S_RS;
                            retire    = 1'b1;
                            state_nxt = S_IF;
                        end
                        default: state_nxt = S_EX;
                    endcase
                end
            end

            S_EX: begin
                case (dec_cls)
                    CLS_R_ALU, CLS_I_ALU: state_nxt = S_WB;
                    CLS_LW, CLS_SW:       state_nxt = S_MEM;
                    CLS_BEQ, CLS_BNE: begin
                        if ((dec_cls == CLS_BEQ) == ZF) begin
                            PC_Write = 1'b1;
                            PC_s     = PC_S_BR;
                        end
                        retire    = 1'b1;
                        state_nxt = S_IF;
                    end
                    default: state_nxt = S_IF;
                endcase
            end

            S_MEM: begin
                mem_req   = 1'b1;
                Mem_Write = (dec_cls == CLS_SW);
                if (mem_done) begin
                    if (dec_cls == CLS_LW) begin
                        state_nxt = S_WB;
                    end else begin
                        retire    = 1'b1;
                        state_nxt = S_IF;
                    end
                end else if (timeout) begin
                    err_set   = 1'b1;
                    err_val   = ERR_MEM_TO;
                    state_nxt = S_HALT;
                end
            end

            S_WB: begin
                Write_Reg = 1'b1;
                case (dec_cls)
                    CLS_LW: begin
                        w_r_s     = WRS_RT;
                        wr_data_s = WDS_MEM;
                    end
                    CLS_I_ALU: begin
                        w_r_s     = WRS_RT;
                        wr_data_s = WDS_ALU;
                    end
                    default: begin
                        w_r_s     = WRS_RD;
                        wr_data_s = WDS_ALU;
                    end
                endcase
                retire    = 1'b1;
                state_nxt = S_IF;
            end

            S_HALT: halted = 1'b1;

            default: state_nxt = S_IF;
        endcase

        // While reset is held every output is quiet, even though the state
        // register already sits in S_IF.
        if (!rst) begin
            mem_req     = 1'b0;
            mem_is_inst = 1'b0;
            IR_Write    = 1'b0;
            PC_Write    = 1'b0;
            PC_s        = PC_S_INC;
            Write_Reg   = 1'b0;
            w_r_s       = WRS_RD;
            wr_data_s   = WDS_ALU;
            rt_imm_s    = 1'b0;
            imm_s       = 1'b0;
            ALU_OP      = ALU_AND;
            Mem_Write   = 1'b0;
            halted      = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IF;
            wait_cnt <= '0;
            err_code <= ERR_NONE;
            inst_cnt <= '0;
        end else begin
            state <= state_nxt;

            // Counts consecutive unanswered request cycles; any completed
            // request or idle cycle restarts it for the next request.
            if (wants_mem && !mem_ready) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (err_set) begin
                err_code <= err_val;
            end

            if (retire) begin
                inst_cnt <= inst_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_mc_ctrl
//  Directed bench for mips_mc_ctrl: walks add, lw with wait states, beq/bne
//  taken and not taken, jal, jr, ori, sw, reset during a store, an illegal
//  opcode halt and a fetch timeout. Inputs change 1 ns after the rising edge;
//  outputs are sampled 2 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_mips_mc_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  OP;
    logic [5:0]  func;
    logic        ZF;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_is_inst;
    logic        IR_Write;
    logic        PC_Write;
    logic [1:0]  PC_s;
    logic        Write_Reg;
    logic [1:0]  w_r_s;
    logic [1:0]  wr_data_s;
    logic        rt_imm_s;
    logic        imm_s;
    logic [2:0]  ALU_OP;
    logic        Mem_Write;
    logic        halted;
    logic [1:0]  err_code;
    logic [31:0] inst_cnt;

    int total = 0;
    int bad   = 0;

    mips_mc_ctrl #(.MEM_TO(16), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .OP          (OP),
        .func        (func),
        .ZF          (ZF),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_is_inst (mem_is_inst),
        .IR_Write    (IR_Write),
        .PC_Write    (PC_Write),
        .PC_s        (PC_s),
        .Write_Reg   (Write_Reg),
        .w_r_s       (w_r_s),
        .wr_data_s   (wr_data_s),
        .rt_imm_s    (rt_imm_s),
        .imm_s       (imm_s),
        .ALU_OP      (ALU_OP),
        .Mem_Write   (Mem_Write),
        .halted      (halted),
        .err_code    (err_code),
        .inst_cnt    (inst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_inst(input logic [31:0] code);
        OP   = code[31:26];
        func = code[5:0];
    endtask

    // One zero-wait fetch cycle; leaves the FSM in ID.
    task automatic fetch(input string tag, input logic [31:0] code);
        set_inst(code);
        mem_ready = 1'b1;
        settle();
        check({tag, " if req"},  {30'd0, mem_req, mem_is_inst}, 32'h3);
        check({tag, " if wr"},   {28'd0, IR_Write, PC_Write, PC_s}, 32'hC);
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        OP        = 6'd0;
        func      = 6'd0;
        ZF        = 1'b0;
        mem_ready = 1'b0;

        // ---- reset state ----
        #2 rst = 1'b0;
        #1;
        check("rst outputs", {16'd0, mem_req, mem_is_inst, IR_Write, PC_Write,
                              Write_Reg, Mem_Write, halted, 9'd0}, 32'h0);
        check("rst err", {30'd0, err_code}, 32'h0);
        check("rst cnt", inst_cnt, 32'h0);
        tick();
        rst = 1'b1;
        settle();

        // ---- add $3,$1,$2 : IF ID EX WB ----
        fetch("add", 32'h0022_1820);
        check("add id idle", {30'd0, mem_req, IR_Write}, 32'h0);
        tick();
        check("add ex alu", {29'd0, ALU_OP}, 32'h4);
        check("add ex b", {30'd0, rt_imm_s, Write_Reg}, 32'h0);
        tick();
        check("add wb", {27'd0, Write_Reg, w_r_s, wr_data_s}, 32'h10);
        check("add wb alu", {29'd0, ALU_OP}, 32'h4);
        tick();
        check("add cnt", inst_cnt, 32'd1);
        check("add back if", {31'd0, mem_is_inst}, 32'h1);

        // ---- lw with 3 wait cycles in IF and 2 in MEM: 10 cycles ----
        set_inst(32'h8C22_0004);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("lw if hold", {30'd0, mem_req, IR_Write}, 32'h2);
            tick();
        end
        mem_ready = 1'b1;
        settle();
        check("lw if done", {30'd0, IR_Write, PC_Write}, 32'h3);
        tick();
        tick();
        check("lw ex", {27'd0, ALU_OP, rt_imm_s, imm_s}, 32'h13);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            settle();
            check("lw mem hold", {29'd0, mem_req, mem_is_inst, Mem_Write}, 32'h4);
            tick();
        end
        mem_ready = 1'b1;
        tick();
        check("lw wb", {27'd0, Write_Reg, w_r_s, wr_data_s}, 32'h15);
        tick();
        check("lw cnt", inst_cnt, 32'd2);
        check("lw back if", {31'd0, mem_is_inst}, 32'h1);

        // ---- beq ZF=1 taken ----
        fetch("beq1", 32'h1022_0003);
        tick();
        ZF = 1'b1;
        settle();
        check("beq1 ex alu", {27'd0, ALU_OP, rt_imm_s, imm_s}, 32'h15);
        check("beq1 ex pc", {29'd0, PC_Write, PC_s}, 32'h6);
        tick();
        check("beq1 cnt", inst_cnt, 32'd3);

        // ---- beq ZF=0 not taken ----
        fetch("beq0", 32'h1022_0003);
        tick();
        ZF = 1'b0;
        settle();
        check("beq0 ex pc", {31'd0, PC_Write}, 32'h0);
        tick();
        check("beq0 if", {31'd0, mem_is_inst}, 32'h1);
        check("beq0 cnt", inst_cnt, 32'd4);

        // ---- bne ZF=0 taken ----
        fetch("bne", 32'h1422_0003);
        tick();
        ZF = 1'b0;
        settle();
        check("bne ex pc", {29'd0, PC_Write, PC_s}, 32'h6);
        tick();
        check("bne cnt", inst_cnt, 32'd5);

        // ---- jal : 2 cycles ----
        fetch("jal", 32'h0C00_0010);
        check("jal id", {26'd0, PC_Write, PC_s, Write_Reg, w_r_s}, 32'h3E);
        check("jal id wd", {30'd0, wr_data_s}, 32'h2);
        tick();
        check("jal cnt", inst_cnt, 32'd6);
        check("jal if", {31'd0, mem_is_inst}, 32'h1);

        // ---- jr $31 ----
        fetch("jr", 32'h03E0_0008);
        check("jr id", {28'd0, PC_Write, PC_s, Write_Reg}, 32'hA);
        tick();
        check("jr cnt", inst_cnt, 32'd7);

        // ---- ori : zero-extended immediate, writes rt ----
        fetch("ori", 32'h3422_00FF);
        tick();
        check("ori ex", {27'd0, ALU_OP, rt_imm_s, imm_s}, 32'h6);
        tick();
        check("ori wb", {27'd0, Write_Reg, w_r_s, wr_data_s}, 32'h14);
        tick();
        check("ori cnt", inst_cnt, 32'd8);

        // ---- sw zero-wait : 4 cycles ----
        fetch("sw", 32'hAC22_0008);
        tick();
        check("sw ex", {27'd0, ALU_OP, rt_imm_s, imm_s}, 32'h13);
        tick();
        check("sw mem", {29'd0, mem_req, mem_is_inst, Mem_Write}, 32'h5);
        check("sw mem no wr", {31'd0, Write_Reg}, 32'h0);
        tick();
        check("sw cnt", inst_cnt, 32'd9);
        check("sw if", {31'd0, mem_is_inst}, 32'h1);

        // ---- reset asserted in the middle of a stalled sw MEM cycle ----
        fetch("swr", 32'hAC22_0008);
        tick();
        mem_ready = 1'b0;
        tick();
        check("swr mem before", {30'd0, mem_req, Mem_Write}, 32'h3);
        #2 rst = 1'b0;
        #1;
        check("swr rst drop", {28'd0, mem_req, Mem_Write, PC_Write, Write_Reg}, 32'h0);
        check("swr rst cnt", inst_cnt, 32'd0);
        tick();
        rst = 1'b1;
        settle();
        check("swr after if", {29'd0, mem_req, mem_is_inst, Mem_Write}, 32'h6);
        check("swr after cnt", inst_cnt, 32'd0);

        // ---- illegal opcode halts; later ready pulses are ignored ----
        fetch("ill", 32'hFC00_0000);
        check("ill id err", {30'd0, err_code}, 32'h0);
        tick();
        check("ill halted", {31'd0, halted}, 32'h1);
        check("ill err", {30'd0, err_code}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i % 2 == 0);
            settle();
            check("halt quiet", {27'd0, mem_req, IR_Write, PC_Write, Write_Reg, Mem_Write}, 32'h0);
            tick();
        end
        check("halt sticky", {29'd0, halted, err_code}, 32'h5);
        check("halt cnt", inst_cnt, 32'd0);

        // ---- fetch timeout after 16 unanswered cycles ----
        rst = 1'b0;
        mem_ready = 1'b0;
        tick();
        rst = 1'b1;
        settle();
        check("to clear", {29'd0, halted, err_code}, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        check("to cycle16", {30'd0, mem_req, halted}, 32'h2);
        tick();
        check("to halted", {29'd0, halted, err_code}, 32'h6);
        check("to quiet", {31'd0, mem_req}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
